// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: hex glyph table, segment bit positions, width helper.
package seg_pkg;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Active-high {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // $clog2 that never yields a zero-width vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex7_decode.sv
// Combinational nibble to active-high seven-segment pattern.
module hex7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX7_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner with tear-free shadow, blanking, LZ suppression and dp.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter int unsigned BLANK_CYCLES   = 1000,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [4*NUM_DIGITS-1:0]              data,
  input  logic                                 load,
  input  logic [NUM_DIGITS-1:0]                dp_mask,
  input  logic                                 blank_lz,
  input  logic                                 enable,
  output logic [NUM_DIGITS-1:0]                an,
  output logic [6:0]                           seg,
  output logic                                 dp,
  output logic [idx_width(NUM_DIGITS)-1:0]     digit_idx,
  output logic                                 frame_tick
);

  localparam int unsigned IdxW = idx_width(NUM_DIGITS);
  localparam int unsigned CntW = idx_width(REFRESH_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AnOff = AN_ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0] SegOff = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic DpOff = SEG_ACTIVE_LOW;

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] staging_q, staging_d, shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   dp_stage_q, dp_stage_d, dp_shadow_q, dp_shadow_d;
  logic                    pending_q, pending_d;
  logic                    frame_tick_q, frame_tick_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    slot_end, wrap;
  logic [3:0]              cur_nib;
  logic [6:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    all_zero;
  logic                    visible, suppressed, dp_bit;
  logic [NUM_DIGITS-1:0]   an_act;
  logic [6:0]              seg_act;

  assign slot_end = enable && (cnt_q == CntLast);
  assign wrap     = slot_end && (idx_q == IdxLast);

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    staging_d    = staging_q;
    dp_stage_d   = dp_stage_q;
    shadow_d     = shadow_q;
    dp_shadow_d  = dp_shadow_q;
    pending_d    = pending_q;
    frame_tick_d = wrap;
    if (enable) cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    if (slot_end) idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    // Shadow copies the pre-load staging, so a coincident load waits for the next wrap.
    if (wrap && pending_q) begin
      shadow_d    = staging_q;
      dp_shadow_d = dp_stage_q;
      pending_d   = 1'b0;
    end
    if (load) begin
      staging_d  = data;
      dp_stage_d = dp_mask;
      pending_d  = 1'b1;
    end
  end

  always_comb begin
    lz_blank = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero    = all_zero && (shadow_q[4*i +: 4] == 4'h0);
      lz_blank[i] = blank_lz && all_zero;
    end
  end

  assign cur_nib = shadow_q[4*idx_q +: 4];

  hex7_decode u_dec (
    .nibble (cur_nib),
    .seg    (seg_raw)
  );

  always_comb begin
    visible    = enable && (32'(cnt_q) >= BLANK_CYCLES);
    suppressed = lz_blank[idx_q];
    dp_bit     = dp_shadow_q[idx_q];
    an_act     = '0;
    // A suppressed digit keeps its anode only when its decimal point must show.
    if (visible && (!suppressed || dp_bit)) an_act[idx_q] = 1'b1;
    seg_act = (visible && !suppressed) ? seg_raw : 7'h00;
    an_d    = AN_ACTIVE_LOW ? ~an_act : an_act;
    seg_d   = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
    dp_d    = SEG_ACTIVE_LOW ? ~(visible && dp_bit) : (visible && dp_bit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      staging_q    <= '0;
      dp_stage_q   <= '0;
      shadow_q     <= '0;
      dp_shadow_q  <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      an_q         <= AnOff;
      seg_q        <= SegOff;
      dp_q         <= DpOff;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      staging_q    <= staging_d;
      dp_stage_q   <= dp_stage_d;
      shadow_q     <= shadow_d;
      dp_shadow_q  <= dp_shadow_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_idx  = idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random traffic against a frame-position model.
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic        load = 1'b0;
  logic [3:0]  dp_mask = '0;
  logic        blank_lz = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;

  // Model: scan position within the frame plus staged/displayed digit values.
  int         pos;
  logic [3:0] sh[ND];
  logic [3:0] st[ND];
  logic [3:0] dsh, dst;
  bit         pend;

  seg_scan_driver #(
    .NUM_DIGITS     (ND),
    .REFRESH_DIV    (RD),
    .BLANK_CYCLES   (BC),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .load       (load),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .enable     (enable),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos = 0;
    for (int j = 0; j < ND; j++) begin
      sh[j] = '0;
      st[j] = '0;
    end
    dsh  = '0;
    dst  = '0;
    pend = 1'b0;
  endtask

  // One clock: predict from pre-edge state, advance model, then compare just after the edge.
  task automatic step();
    int         slot, off;
    bit         vis, supp, ft_e;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    slot = pos / RD;
    off  = pos % RD;
    vis  = enable && (off >= BC);
    supp = blank_lz && (slot > 0);
    for (int j = slot; j < ND; j++) if (sh[j] != 4'h0) supp = 1'b0;
    an_e  = (vis && (!supp || dsh[slot])) ? ~(4'b0001 << slot) : 4'hF;
    seg_e = (vis && !supp) ? ~seg7(sh[slot]) : 7'h7F;
    dp_e  = !(vis && dsh[slot]);
    ft_e  = enable && (pos == FRAME - 1);
    @(posedge clk);
    if (ft_e && pend) begin
      sh   = st;
      dsh  = dst;
      pend = 1'b0;
    end
    if (load) begin
      for (int j = 0; j < ND; j++) st[j] = data[4*j +: 4];
      dst  = dp_mask;
      pend = 1'b1;
    end
    if (enable) pos = (pos + 1) % FRAME;
    #1;
    chk("an", 32'(an), 32'(an_e));
    chk("seg", 32'(seg), 32'(seg_e));
    chk("dp", 32'(dp), 32'(dp_e));
    chk("frame_tick", 32'(frame_tick), 32'(ft_e));
    chk("digit_idx", 32'(digit_idx), 32'(pos / RD));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (pos != target && n < 2 * FRAME) begin
      step();
      n++;
    end
    if (pos != target) chk("run_to_bound", 32'(pos), 32'(target));
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] m);
    data    = d;
    dp_mask = m;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_dp", 32'(dp), 32'h1);
    chk("reset_tick", 32'(frame_tick), 32'h0);
    chk("reset_idx", 32'(digit_idx), 32'h0);
    enable = 1'b1;
    rst_n  = 1'b1;

    // Basic scan of 12AF.
    pulse_load(16'h12AF, 4'h0);
    run(2 * FRAME);

    // Load zeros during slot 2: rest of this frame keeps old digits.
    run_to(2 * RD + 3);
    pulse_load(16'h0000, 4'h0);
    run(FRAME + 8);

    // Leading-zero suppression.
    blank_lz = 1'b1;
    pulse_load(16'h0050, 4'h0);
    run(2 * FRAME);
    pulse_load(16'h0000, 4'h0);
    run(2 * FRAME);

    // Decimal point on a suppressed digit.
    pulse_load(16'h0007, 4'b0100);
    run(2 * FRAME);
    blank_lz = 1'b0;

    // Load coinciding with the wrap after a pending 1111.
    run_to(RD + 1);
    pulse_load(16'h1111, 4'h0);
    run_to(FRAME - 1);
    pulse_load(16'hBEEF, 4'h0);
    run(2 * FRAME);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      load = ($urandom % 8) == 0;
      if (load) begin
        data    = 16'($urandom) >> (4 * ($urandom % 4));
        dp_mask = 4'($urandom);
      end
      if (($urandom % 16) == 0) enable = ~enable;
      if (($urandom % 32) == 0) blank_lz = ~blank_lz;
      step();
    end
    load     = 1'b0;
    enable   = 1'b1;
    blank_lz = 1'b0;
    pulse_load(16'h4321, 4'h0);
    run(FRAME);

    // Freeze mid-slot, resume, then asynchronous reset while an anode is lit.
    run_to(RD + 4);
    enable = 1'b0;
    run(20);
    enable = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'hF);
    chk("async_seg", 32'(seg), 32'h7F);
    chk("async_dp", 32'(dp), 32'h1);
    chk("async_idx", 32'(digit_idx), 32'h0);
    chk("async_tick", 32'(frame_tick), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    chk("release_idx", 32'(digit_idx), 32'h0);
    run(FRAME + 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
